conv2d_stream: RTL and testbench



---
 rtl/conv2d_stream_if.sv | 24 ++
 rtl/conv2d_stream.sv | 176 +++++++++++++++++
 tb/tb_conv2d_stream.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_stream_if.sv
// Pixel-in / result-out stream of conv2d_stream. The slave side is the convolver;
// the master side is the pixel producer and the result consumer.
interface conv2d_stream_if #(
    parameter int N       = 8,
    parameter int AccBits = 20
);
    logic [N-1:0]       data_i;
    logic               data_valid_i;
    logic               data_ready_o;
    logic [AccBits-1:0] conv_o;
    logic               conv_valid_o;
    logic [13:0]        conv_row_o;
    logic [13:0]        conv_col_o;

    modport slave (
        input  data_i, data_valid_i,
        output data_ready_o, conv_o, conv_valid_o, conv_row_o, conv_col_o
    );

    modport master (
        output data_i, data_valid_i,
        input  data_ready_o, conv_o, conv_valid_o, conv_row_o, conv_col_o
    );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming KxK convolver: K-1 line buffers feed a KxK window, 2-stage MAC, tagged outputs.
// Optional: define CONV2D_STREAM_RELU_EN to clamp negative results to 0.
module conv2d_stream #(
    parameter int MaxMatrixSize = 64,
    parameter int KernelSize    = 3,
    parameter int N             = 8,
    parameter int AccBits       = 2*N+$clog2(KernelSize*KernelSize)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      start_i,
    input  logic [13:0]                               width_i,
    input  logic [13:0]                               height_i,
    input  logic [5:0]                                stride_i,
    input  logic [KernelSize*KernelSize-1:0][N-1:0]   weights_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      err_o,
    conv2d_stream_if.slave                            s
);
    localparam int K  = KernelSize;
    localparam int KK = K * K;
    localparam int AW = $clog2(MaxMatrixSize);
    localparam logic [13:0] KM1   = 14'(K - 1);
    localparam logic [13:0] K14   = 14'(K);
    localparam logic [13:0] MAX14 = 14'(MaxMatrixSize);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                      state_q, state_d;
    logic                        drain_q, drain_d;
    logic [13:0]                 w_q, w_d, h_q, h_d;
    logic [5:0]                  s_q, s_d, cph_q, cph_d, rph_q, rph_d;
    logic [KK-1:0][N-1:0]        wt_q, wt_d;
    logic [13:0]                 col_q, col_d, row_q, row_d, ocol_q, ocol_d, orow_q, orow_d;
    logic [K-1:0][K-1:0][N-1:0]  win_q, win_d, win_n;
    logic [KK-1:0][2*N-1:0]      prod_q, prod_d;
    logic [1:0]                  vld_q, vld_d;
    logic [13:0]                 trow_q, trow_d, tcol_q, tcol_d, crow_q, crow_d, ccol_q, ccol_d;
    logic [AccBits-1:0]          conv_q, conv_d, sum;
    logic                        err_q, err_d;
    logic [N-1:0]                lb_q [K-1][MaxMatrixSize];
    logic [K-2:0][N-1:0]         lb_col_d;
    logic [AW-1:0]               addr;
    logic                        accept, legal, last_col, last_row, col_in, row_in, emit;

    always_comb begin
        addr     = col_q[AW-1:0];
        accept   = s.data_valid_i && (state_q == RUN);
        legal    = (width_i >= K14) && (height_i >= K14) && (stride_i != '0) &&
                   (width_i <= MAX14) && (height_i <= MAX14);
        last_col = (col_q == w_q - 14'd1);
        last_row = (row_q == h_q - 14'd1);
        col_in   = (col_q >= KM1);
        row_in   = (row_q >= KM1);
        // Phase counters are zero exactly on stride-aligned rows/columns.
        emit     = accept && col_in && row_in && (cph_q == '0) && (rph_q == '0);

        for (int r = 0; r < K; r++)
            for (int c = 0; c < K-1; c++)
                win_n[r][c] = win_q[r][c+1];
        for (int r = 0; r < K-1; r++)
            win_n[r][K-1] = lb_q[r][addr];
        win_n[K-1][K-1] = s.data_i;
        for (int i = 0; i < K-2; i++)
            lb_col_d[i] = lb_q[i+1][addr];
        lb_col_d[K-2] = s.data_i;

        state_d = state_q;  drain_d = drain_q;  err_d = 1'b0;
        w_d = w_q;  h_d = h_q;  s_d = s_q;  wt_d = wt_q;
        col_d = col_q;  row_d = row_q;  cph_d = cph_q;  rph_d = rph_q;
        ocol_d = ocol_q;  orow_d = orow_q;  win_d = win_q;

        case (state_q)
            IDLE: if (start_i) begin
                if (legal) begin
                    state_d = RUN;
                    w_d = width_i;  h_d = height_i;  s_d = stride_i;  wt_d = weights_i;
                    col_d = '0;  row_d = '0;  cph_d = '0;  rph_d = '0;
                    ocol_d = '0;  orow_d = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
            RUN: if (accept && last_col && last_row) begin
                state_d = DRAIN;
                drain_d = 1'b0;
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            win_d = win_n;
            if (last_col) begin
                col_d = '0;  cph_d = '0;  ocol_d = '0;
                row_d = last_row ? 14'd0 : row_q + 14'd1;
                if (row_in) begin
                    rph_d = (rph_q == s_q - 6'd1) ? 6'd0 : rph_q + 6'd1;
                    if (rph_q == '0) orow_d = orow_q + 14'd1;
                end
            end else begin
                col_d = col_q + 14'd1;
                if (col_in) begin
                    cph_d = (cph_q == s_q - 6'd1) ? 6'd0 : cph_q + 6'd1;
                    if (cph_q == '0) ocol_d = ocol_q + 14'd1;
                end
            end
        end
    end

    always_comb begin
        prod_d = prod_q;  trow_d = trow_q;  tcol_d = tcol_q;
        vld_d  = {vld_q[0], emit};
        if (emit) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    prod_d[r*K+c] = $signed(win_n[r][c]) * $signed(wt_q[r*K+c]);
            trow_d = orow_q;
            tcol_d = ocol_q;
        end

        sum = '0;
        for (int i = 0; i < KK; i++)
            sum = sum + {{(AccBits-2*N){prod_q[i][2*N-1]}}, prod_q[i]};

        conv_d = conv_q;  crow_d = crow_q;  ccol_d = ccol_q;
        if (vld_q[0]) begin
`ifdef CONV2D_STREAM_RELU_EN
            conv_d = sum[AccBits-1] ? '0 : sum;
`else
            conv_d = sum;
`endif
            crow_d = trow_q;
            ccol_d = tcol_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;  drain_q <= 1'b0;  err_q <= 1'b0;
            w_q <= '0;  h_q <= '0;  s_q <= '0;  wt_q <= '0;
            col_q <= '0;  row_q <= '0;  cph_q <= '0;  rph_q <= '0;
            ocol_q <= '0;  orow_q <= '0;  win_q <= '0;
            prod_q <= '0;  vld_q <= '0;  trow_q <= '0;  tcol_q <= '0;
            conv_q <= '0;  crow_q <= '0;  ccol_q <= '0;
        end else begin
            state_q <= state_d;  drain_q <= drain_d;  err_q <= err_d;
            w_q <= w_d;  h_q <= h_d;  s_q <= s_d;  wt_q <= wt_d;
            col_q <= col_d;  row_q <= row_d;  cph_q <= cph_d;  rph_q <= rph_d;
            ocol_q <= ocol_d;  orow_q <= orow_d;  win_q <= win_d;
            prod_q <= prod_d;  vld_q <= vld_d;  trow_q <= trow_d;  tcol_q <= tcol_d;
            conv_q <= conv_d;  crow_q <= crow_d;  ccol_q <= ccol_d;
        end
    end

    // Line buffers are plain storage: never cleared, only written on accept.
    always_ff @(posedge clk_i) begin
        if (accept)
            for (int i = 0; i < K-1; i++)
                lb_q[i][addr] <= lb_col_d[i];
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign err_o          = err_q;
    assign s.data_ready_o = (state_q == RUN);
    assign s.conv_valid_o = vld_q[1];
    assign s.conv_o       = conv_q;
    assign s.conv_row_o   = crow_q;
    assign s.conv_col_o   = ccol_q;
endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: directed and random frames against a window-sum model.
module tb_conv2d_stream;
    localparam int K  = 3;
    localparam int KK = K * K;
    localparam int NB = 8;
    localparam int AB = 2*NB + $clog2(KK);

    typedef struct { int cyc; int val; int row; int col; } out_t;

    logic                  clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [13:0]           width = '0, height = '0;
    logic [5:0]            stride = '0;
    logic [KK-1:0][NB-1:0] weights = '0;
    logic                  busy, done, err;
    int                    checks = 0, errors = 0, cyc = 0;
    int                    pix [4096];
    int                    acc_cyc [4096];
    int                    wt [KK];
    out_t                  outq [$];
    int                    done_q [$];

    conv2d_stream_if #(.N(NB), .AccBits(AB)) bus ();

    conv2d_stream #(.MaxMatrixSize(64), .KernelSize(K), .N(NB)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .width_i(width), .height_i(height),
        .stride_i(stride), .weights_i(weights), .busy_o(busy), .done_o(done), .err_o(err),
        .s(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        out_t o;
        if (!rst) begin
            if (bus.conv_valid_o) begin
                o.cyc = cyc;  o.val = int'($signed(bus.conv_o));
                o.row = int'(bus.conv_row_o);  o.col = int'(bus.conv_col_o);
                outq.push_back(o);
            end
            if (done) done_q.push_back(cyc);
        end
    end

    task automatic fill_basic();
        for (int i = 0; i < KK; i++) wt[i] = 1;
        for (int i = 0; i < 25; i++) pix[i] = i + 1;
    endtask

    task automatic do_start(input int w, input int h, input int s);
        width = 14'(w);  height = 14'(h);  stride = 6'(s);
        for (int i = 0; i < KK; i++) weights[i] = 8'(wt[i]);
        outq.delete();  done_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: continuous, 1: valid every other cycle, 2: random gaps
    task automatic drive_frame(input int w, input int h, input int mode, input int max_acc);
        int idx = 0, g = 0;
        bit v;
        while (idx < max_acc && g < 20000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : ($urandom_range(0, 2) != 0);
            bus.data_valid_i = v;
            bus.data_i = 8'(pix[idx]);
            @(negedge clk);
            if (v && bus.data_ready_o) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
            g++;
        end
        bus.data_valid_i = 1'b0;
        checks++;
        if (idx != max_acc) begin
            errors++;
            $display("FAIL drive_accepts got %0d want %0d (w=%0d h=%0d)", idx, max_acc, w, h);
        end
    endtask

    task automatic check_frame(input string tag, input int w, input int h, input int s);
        int g = 0, n = 0, e, ec, dc;
        while (done_q.size() == 0 && g < 40) begin @(posedge clk); #1; g++; end
        repeat (4) begin @(posedge clk); #1; end
        dc = (done_q.size() > 0) ? done_q[0] : -1;
        checks++;
        if (done_q.size() != 1 || dc != acc_cyc[w*h-1] + 3) begin
            errors++;
            $display("FAIL %s done got cyc %0d (n=%0d) want %0d", tag, dc, done_q.size(), acc_cyc[w*h-1] + 3);
        end
        for (int orr = 0; orr*s + K-1 < h; orr++) begin
            for (int oc = 0; oc*s + K-1 < w; oc++) begin
                e = 0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        e += pix[(orr*s + r)*w + oc*s + c] * wt[r*K + c];
`ifdef CONV2D_STREAM_RELU_EN
                if (e < 0) e = 0;
`endif
                ec = acc_cyc[(orr*s + K-1)*w + oc*s + K-1] + 2;
                checks++;
                if (n >= outq.size()) begin
                    errors++;
                    $display("FAIL %s out%0d missing want %0d @(%0d,%0d)", tag, n, e, orr, oc);
                end else if (outq[n].val !== e || outq[n].row !== orr || outq[n].col !== oc || outq[n].cyc !== ec) begin
                    errors++;
                    $display("FAIL %s out%0d got %0d @(%0d,%0d) cyc %0d want %0d @(%0d,%0d) cyc %0d", tag, n,
                             outq[n].val, outq[n].row, outq[n].col, outq[n].cyc, e, orr, oc, ec);
                end
                n++;
            end
        end
        checks++;
        if (outq.size() != n) begin
            errors++;
            $display("FAIL %s out_count got %0d want %0d", tag, outq.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.data_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy_ready got %b%b want 00", busy, bus.data_ready_o);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || bus.conv_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got %b%b%b want 000", done, err, bus.conv_valid_o);
        end
        checks++;
        if (bus.conv_o !== '0 || bus.conv_row_o !== '0 || bus.conv_col_o !== '0) begin
            errors++; $display("FAIL reset_data got %0h %0d %0d want 0", bus.conv_o, bus.conv_row_o, bus.conv_col_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        fill_basic();
        do_start(4, 4, 1);
        drive_frame(4, 4, 0, 16);
        check_frame("basic", 4, 4, 1);
        checks++;
        if (outq.size() < 1 || outq[0].val !== 54) begin
            errors++; $display("FAIL basic_first got %0d want 54", (outq.size() > 0) ? outq[0].val : -1);
        end
    endtask

    task automatic test_stride2();
        fill_basic();
        do_start(5, 5, 2);
        drive_frame(5, 5, 0, 25);
        check_frame("stride2", 5, 5, 2);
    endtask

    task automatic test_stalls();
        fill_basic();
        do_start(4, 4, 1);
        drive_frame(4, 4, 1, 16);
        check_frame("stalls", 4, 4, 1);
    endtask

    task automatic test_signed();
        for (int i = 0; i < KK; i++) wt[i] = -1;
        for (int i = 0; i < 9; i++) pix[i] = 2;
        do_start(3, 3, 1);
        drive_frame(3, 3, 0, 9);
        check_frame("signed", 3, 3, 1);
    endtask

    task automatic test_random();
        int w, h, s;
        for (int f = 0; f < 5; f++) begin
            w = $urandom_range(3, 9);  h = $urandom_range(3, 9);  s = $urandom_range(1, 4);
            for (int i = 0; i < KK; i++) wt[i] = $urandom_range(0, 255) - 128;
            for (int i = 0; i < w*h; i++) pix[i] = $urandom_range(0, 255) - 128;
            do_start(w, h, s);
            drive_frame(w, h, 2, w*h);
            check_frame("random", w, h, s);
        end
    endtask

    task automatic test_illegal();
        int bw [3], bs [3];
        bw[0] = 4;  bs[0] = 0;
        bw[1] = 2;  bs[1] = 1;
        bw[2] = 65; bs[2] = 1;
        for (int i = 0; i < 3; i++) begin
            width = 14'(bw[i]);  height = 14'd4;  stride = 6'(bs[i]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || bus.data_ready_o !== 1'b0) begin
                errors++; $display("FAIL illegal%0d err/busy/ready got %b%b%b want 100", i, err, busy, bus.data_ready_o);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL illegal%0d pulse_end err/busy got %b%b want 00", i, err, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_busy();
        fill_basic();
        do_start(4, 4, 1);
        width = 14'd10;  stride = 6'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || bus.data_ready_o !== 1'b1) begin
            errors++; $display("FAIL start_busy err/busy/ready got %b%b%b want 011", err, busy, bus.data_ready_o);
        end
        @(posedge clk); #1;
        drive_frame(4, 4, 0, 16);
        check_frame("start_busy", 4, 4, 1);
    endtask

    task automatic test_midreset(input int nacc);
        fill_basic();
        do_start(4, 4, 1);
        drive_frame(4, 4, 0, nacc);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.data_ready_o !== 1'b0 || bus.conv_valid_o !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || bus.conv_o !== '0 || bus.conv_row_o !== '0 || bus.conv_col_o !== '0) begin
            errors++; $display("FAIL midreset%0d outputs busy=%b rdy=%b vld=%b conv=%0h want all 0", nacc, busy,
                               bus.data_ready_o, bus.conv_valid_o, bus.conv_o);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (outq.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset%0d killed got %0d outputs busy=%b want 0", nacc, outq.size(), busy);
        end
        do_start(4, 4, 1);
        drive_frame(4, 4, 0, 16);
        check_frame("after_reset", 4, 4, 1);
    endtask

    initial begin
        bus.data_i = '0;
        bus.data_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_stride2();
        test_stalls();
        test_signed();
        test_illegal();
        test_start_busy();
        test_midreset(7);
        test_midreset(11);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
